// File: rtl/nn_stream_adapter.sv
// nn_stream_adapter: collects 22 16-bit feature words into registers that
// feed a combinational network, waits SETTLE cycles for the network to
// settle, captures its four 32-bit outputs together with their argmax, then
// streams the four results out with a valid/ready handshake.
module nn_stream_adapter #(
    parameter int SETTLE = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [351:0] nn_in,
    input  logic [127:0] nn_out,
    output logic [31:0]  m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         m_last,
    output logic [1:0]   m_class,
    output logic         busy
);

    localparam int         NFEAT       = 22;
    localparam logic [4:0] LAST_IDX    = 5'd21;
    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SETTLE,
        ST_SEND
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] feature [NFEAT];
    logic [4:0]  idx;
    logic [7:0]  cnt;
    logic [31:0] result [4];
    logic [1:0]  oidx;
    logic [1:0]  cls;

    logic        s_fire;
    logic        m_fire;
    logic        load_done;
    logic        settle_done;
    logic        send_done;

    logic [31:0] best_val;
    logic [1:0]  argmax;

    // Handshake qualifiers: a word moves only when both sides agree.
    assign s_fire      = s_valid && s_ready;
    assign m_fire      = m_valid && m_ready;
    assign load_done   = s_fire && (idx == LAST_IDX);
    assign settle_done = (state == ST_SETTLE) && (cnt == 8'd1);
    assign send_done   = m_fire && (oidx == 2'd3);

    // The result stream always shows the word selected by the output index.
    assign m_data  = result[oidx];
    assign m_last  = m_valid && (oidx == 2'd3);
    assign m_class = cls;

    // Network inputs come straight from the feature registers, lane k at 16k.
    for (genvar k = 0; k < NFEAT; k++) begin : g_lanes
        assign nn_in[16*k +: 16] = feature[k];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; everything is held low during reset.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        busy       = 1'b0;
        if (!rst) begin
            unique case (state)
                ST_LOAD: begin
                    s_ready = 1'b1;
                    if (load_done) begin
                        state_next = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    busy = 1'b1;
                    if (settle_done) begin
                        state_next = ST_SEND;
                    end
                end
                ST_SEND: begin
                    busy    = 1'b1;
                    m_valid = 1'b1;
                    if (send_done) begin
                        state_next = ST_LOAD;
                    end
                end
                default: begin
                    state_next = ST_LOAD;
                end
            endcase
        end
    end

    // Each feature register is written only when its own word is accepted.
    for (genvar k = 0; k < NFEAT; k++) begin : g_feat
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                feature[k] <= '0;
            end else if (s_fire && (idx == 5'(k))) begin
                feature[k] <= s_data;
            end
        end
    end

    // Input word index: counts accepted words and wraps after the 22nd.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (load_done) begin
            idx <= '0;
        end else if (s_fire) begin
            idx <= idx + 5'd1;
        end
    end

    // Settle counter: loaded on the last feature, counts down to one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load_done) begin
            cnt <= SETTLE_INIT;
        end else if (state == ST_SETTLE) begin
            cnt <= cnt - 8'd1;
        end
    end

    // Argmax of the four network outputs; strict compare keeps ties low.
    always_comb begin
        best_val = nn_out[31:0];
        argmax   = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (nn_out[32*i +: 32] > best_val) begin
                best_val = nn_out[32*i +: 32];
                argmax   = 2'(i);
            end
        end
    end

    // Capture the settled network outputs and their class in one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                result[i] <= '0;
            end
            cls <= '0;
        end else if (settle_done) begin
            for (int i = 0; i < 4; i++) begin
                result[i] <= nn_out[32*i +: 32];
            end
            cls <= argmax;
        end
    end

    // Output word index: advances on each accepted result, wraps after four.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oidx <= '0;
        end else if (send_done) begin
            oidx <= '0;
        end else if (m_fire) begin
            oidx <= oidx + 2'd1;
        end
    end

endmodule

// File: doc/nn_stream_adapter.md
NN_STREAM_ADAPTER -- requirements
Module: nn_stream_adapter

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, giving the number of cycles the network is allowed to settle before its outputs are sampled; legal range is 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset; it is asynchronous and active-high.
REQ-004 The block SHALL have port s_data, input, 16 bits, the feature word.
REQ-005 The block SHALL have port s_valid, input, 1 bit, asserted when the feature word is valid.
REQ-006 The block SHALL have port s_ready, output, 1 bit, asserted when the block can accept a feature word.
REQ-007 The block SHALL have port nn_in, output, 352 bits, the network inputs in0..in21, with in0 at [15:0] and ink at [16k+15:16k].
REQ-008 The block SHALL have port nn_out, input, 128 bits, the network outputs out1..out4, with out1 at [31:0] and out4 at [127:96].
REQ-009 The block SHALL have port m_data, output, 32 bits, the result word.
REQ-010 The block SHALL have port m_valid, output, 1 bit, asserted when the result word is valid.
REQ-011 The block SHALL have port m_ready, input, 1 bit, asserted when the sink can accept a result word.
REQ-012 The block SHALL have port m_last, output, 1 bit, marking the 4th result word.
REQ-013 The block SHALL have port m_class, output, 2 bits, the argmax index, valid whenever m_valid is high.
REQ-014 The block SHALL have port busy, output, 1 bit, high in every state other than LOAD.

Function
REQ-015 The FSM SHALL have states LOAD, SETTLE and SEND, and SHALL encode nothing beyond them.
REQ-016 In LOAD, s_ready=1; each cycle with s_valid&&s_ready SHALL write s_data to feature[idx] and increment idx (5 bits); gaps in s_valid SHALL stall without loss.
REQ-017 Accepting the word at idx==21 SHALL move the FSM to SETTLE, set idx=0, and load the settle counter with SETTLE.
REQ-018 nn_in SHALL always drive the 22 feature registers directly (no combinational path from s_data); a register SHALL change only when its own word is accepted.
REQ-019 In SETTLE, s_ready=0 and the counter SHALL decrement once per cycle; the FSM SHALL remain in SETTLE for exactly SETTLE cycles.
REQ-020 On the clock edge ending the last SETTLE cycle, the block SHALL register nn_out into result[0..3] and the argmax into the class register, and the FSM SHALL move to SEND.
REQ-021 Argmax SHALL be an unsigned 32-bit compare of out1..out4 mapped to class 0..3; ties SHALL resolve to the lowest index.
REQ-022 In SEND, m_valid=1 and m_data=result[oidx]; m_last SHALL equal (oidx==3); m_class SHALL be held constant.
REQ-023 The output index oidx SHALL advance only on m_valid&&m_ready; m_data SHALL be held stable while m_ready=0.
REQ-024 Acceptance at oidx==3 SHALL set oidx=0 and move the FSM to LOAD, with s_ready=1 on the next cycle.
REQ-025 Latency SHALL be as follows: when the 22nd feature is accepted at edge T, m_valid rises after edge T+SETTLE and the first result is sampled from nn_out during cycle T+SETTLE.
REQ-026 s_valid SHALL be ignored outside LOAD, and m_ready SHALL be ignored outside SEND.

Reset
REQ-027 When rst is asserted at any time, including mid-LOAD, mid-SETTLE or mid-SEND, the block SHALL immediately enter LOAD, clear idx, oidx and the counter, zero all features, results and class, and force m_valid=0, m_last=0, busy=0 and s_ready=0 while rst=1.
REQ-028 After rst is released, s_ready SHALL be 1 and any partial load or partial send SHALL be discarded.

Verification
REQ-029 Stub nn_out = {out4=1, out3=9, out2=9, out1=5}, SETTLE=2; stream 22 words of 0x0002 back-to-back -> nn_in has every lane =0x0002, m_valid rises 2 edges after the last accept, m_data sequence is 5, 9, 9, 1 with m_last on the 4th word, and m_class=1 (tie resolves low).
REQ-030 Stream 22 words with a first word of 0x0016 and s_valid low every other cycle -> nn_in[15:0]=0x0016, all 22 lanes correct, and no word dropped or duplicated.
REQ-031 Hold m_ready=0 for 3 cycles at oidx=2 -> m_data stays 9 and m_valid stays 1; then m_ready=1 -> 1 is delivered with m_last=1, and s_ready=1 on the next cycle.
REQ-032 Assert rst during SEND at oidx=1 -> m_valid=0 immediately and nn_in=0; after release, a full new load produces a complete 4-word burst.
REQ-033 SETTLE=1 with nn_out changed during SETTLE -> the captured values equal nn_out in the single SETTLE cycle; toggling s_valid during SETTLE or SEND changes no feature register.
